// File: rtl/hs_merge_ctrl_pkg.sv
// hs_merge_ctrl_pkg: flit layout, merge key and field helpers shared by the HS merge buffer.
package hs_merge_ctrl_pkg;
  localparam int NUM_PORT       = 5;
  localparam int LO_PAYLOAD_POS = 0;
  localparam int SRC_LIST_POS   = 8;
  localparam int DST_POS        = 13;
  localparam int DST_W          = 3;
  localparam int MEM_ADDR_POS   = 16;
  localparam int ADDR_W         = 8;
  localparam int HS_POS         = 24;
  localparam int HS_W           = 2;
  localparam int IR_DATA_WIDTH  = 26;
  localparam int KEY_W          = HS_W + ADDR_W + DST_W;
  typedef logic [IR_DATA_WIDTH-1:0] flit_t;
  typedef logic [KEY_W-1:0] key_t;
  function automatic key_t key_of(input flit_t f);
    return {f[HS_POS +: HS_W], f[MEM_ADDR_POS +: ADDR_W], f[DST_POS +: DST_W]};
  endfunction
  function automatic logic [NUM_PORT-1:0] src_of(input flit_t f);
    return f[SRC_LIST_POS +: NUM_PORT];
  endfunction
endpackage

// File: rtl/hs_merge_ctrl_key_match.sv
// hs_key_match: equality compare of two HS merge keys.
module hs_key_match
  import hs_merge_ctrl_pkg::*;
(
  input  key_t a_i,
  input  key_t b_i,
  output logic eq_o
);
  assign eq_o = a_i == b_i;
endmodule

// File: rtl/hs_merge_ctrl.sv
// hs_merge_ctrl: circular merge queue that folds same-key HS flits together and drains them in FIFO order.
module hs_merge_ctrl
  import hs_merge_ctrl_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORT-1:0]               in_valid,
  input  logic [NUM_PORT*IR_DATA_WIDTH-1:0] flit_in,
  output logic [NUM_PORT-1:0]               kill,
  output logic                              out_valid,
  output logic [IR_DATA_WIDTH-1:0]          out_data,
  input  logic                              out_ready,
  output logic [$clog2(DEPTH):0]            occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  flit_t fl [NUM_PORT];
  flit_t ent_q [DEPTH];
  logic [CNT_W-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] vld_q, unl;
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] cnt_q;
  logic lock, pop, do_alloc;
  logic [NUM_PORT-1:0] hit, fresh, a_oh, sm, a_src;
  logic [NUM_PORT-1:0][DEPTH-1:0] meq, mt;
  logic [NUM_PORT-1:0][NUM_PORT-1:0] peq;
  logic [NUM_PORT-1:0] msrc [DEPTH];
  flit_t a_flit, new_ent;
  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    assign fl[p] = flit_in[p*IR_DATA_WIDTH +: IR_DATA_WIDTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      hs_key_match u_pe (.a_i(key_of(fl[p])), .b_i(key_of(ent_q[i])), .eq_o(meq[p][i]));
    end
    for (genvar q = 0; q < NUM_PORT; q++) begin : g_pp
      if (q > p) begin : g_cmp
        hs_key_match u_pp (.a_i(key_of(fl[p])), .b_i(key_of(fl[q])), .eq_o(peq[p][q]));
      end else begin : g_tie
        assign peq[p][q] = 1'b0;
      end
    end
  end
  // Only the head can ever be locked, and lock depends on registered state alone.
  assign lock      = vld_q[head_q] && (age_q[head_q] == HOLD || cnt_q == FULL);
  assign pop       = lock && out_ready;
  assign out_valid = lock;
  assign out_data  = ent_q[head_q];
  assign occupancy = cnt_q;
  always_comb begin
    hit = '0;
    mt = '0;
    a_oh = '0;
    sm = '0;
    a_src = '0;
    a_flit = '0;
    for (int i = 0; i < DEPTH; i++) unl[i] = vld_q[i] && !(lock && head_q == PW'(i));
    for (int p = 0; p < NUM_PORT; p++)
      for (int i = 0; i < DEPTH; i++)
        if (in_valid[p] && unl[i] && meq[p][i] && !hit[p]) begin
          mt[p][i] = 1'b1;
          hit[p] = 1'b1;
        end
    fresh = in_valid & ~hit;
    for (int p = 0; p < NUM_PORT; p++) if (fresh[p] && a_oh == '0) a_oh[p] = 1'b1;
    do_alloc = |a_oh && cnt_q != FULL;
    for (int p = 0; p < NUM_PORT; p++) begin
      sm[p] = a_oh[p];
      for (int q = 0; q < p; q++) sm[p] = sm[p] | (a_oh[q] & peq[q][p]);
    end
    sm = do_alloc ? sm & fresh : '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (sm[p]) a_src = a_src | src_of(fl[p]);
      if (a_oh[p]) a_flit = fl[p];
    end
    new_ent = a_flit;
    new_ent[SRC_LIST_POS +: NUM_PORT] = a_src;
    for (int i = 0; i < DEPTH; i++) begin
      msrc[i] = '0;
      for (int p = 0; p < NUM_PORT; p++) if (mt[p][i]) msrc[i] = msrc[i] | src_of(fl[p]);
    end
    kill = hit | sm;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && age_q[i] != HOLD) age_q[i] <= age_q[i] + 1'b1;
        ent_q[i][SRC_LIST_POS +: NUM_PORT] <= ent_q[i][SRC_LIST_POS +: NUM_PORT] | msrc[i];
        if (pop && head_q == PW'(i)) vld_q[i] <= 1'b0;
        if (do_alloc && tail_q == PW'(i)) begin
          ent_q[i] <= new_ent;
          vld_q[i] <= 1'b1;
          age_q[i] <= '0;
        end
      end
      if (pop) head_q <= head_q + 1'b1;
      if (do_alloc) tail_q <= tail_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(do_alloc) - (PW+1)'(pop);
    end
  end
endmodule
